// File: rtl/mer_measure_sequencer_pkg.sv
// Shared definitions for the MER measurement sequencer.
//   seq_state_t : sequencer FSM state encoding (IDLE=0 .. REPORT=4)
//   PHASE_W     : width of the free-running phase counter (32 cycles per symbol)
//   SYM_PHASE   : phase value on which the symbol enable fires
//   SMP_MASK    : low phase bits that must all be set for the sample enable
package mer_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SETTLE = 3'd2,
        ACCUM  = 3'd3,
        REPORT = 3'd4
    } seq_state_t;

    localparam int               PHASE_W   = 5;
    localparam logic [PHASE_W-1:0] SYM_PHASE = 5'd31;
    localparam logic [2:0]       SMP_MASK  = 3'b111;

endpackage

// File: rtl/mer_measure_sequencer_if.sv
// Control / status bundle of the MER measurement sequencer.
//   master : the sequencer itself (takes requests and res_ready, drives enables,
//            strobes, result handshake and counters)
//   slave  : the surrounding logic (key/switch control, accumulators, MER readout)
// Signals:
//   start, continuous, abort : measurement requests
//   res_valid / res_ready    : interval-result handshake
//   clk_en, smp_en, sym_en   : free-running rate enables
//   clear_accum, capture     : symbol-aligned accumulator strobes
//   busy, sym_count, interval_count : status
interface mer_measure_sequencer_if #(
    parameter int ACC_LEN_LOG2 = 18,
    parameter int CNT_W        = 16
) ();
    logic                    start;
    logic                    continuous;
    logic                    abort;
    logic                    res_ready;
    logic                    clk_en;
    logic                    smp_en;
    logic                    sym_en;
    logic                    clear_accum;
    logic                    capture;
    logic                    res_valid;
    logic                    busy;
    logic [ACC_LEN_LOG2-1:0] sym_count;
    logic [CNT_W-1:0]        interval_count;

    modport master (
        input  start, continuous, abort, res_ready,
        output clk_en, smp_en, sym_en, clear_accum, capture,
               res_valid, busy, sym_count, interval_count
    );

    modport slave (
        output start, continuous, abort, res_ready,
        input  clk_en, smp_en, sym_en, clear_accum, capture,
               res_valid, busy, sym_count, interval_count
    );
endinterface

// File: rtl/mer_enable_gen.sv
// Rate-enable generator: a 5-bit phase counter free-running on CLOCK_50 with
// clock-enable decodes taken from the registered phase.
// Ports:
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high; phase returns to 0
//   clk_en   : CLOCK_50/2 enable (phase[0])
//   smp_en   : sample enable, one cycle in 8
//   sym_en   : symbol enable, one cycle in 32
module mer_enable_gen
    import mer_seq_pkg::*;
(
    input  logic CLOCK_50,
    input  logic reset,
    output logic clk_en,
    output logic smp_en,
    output logic sym_en
);

    logic [PHASE_W-1:0] phase_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_reg + 1'b1;
        end
    end

    // Decodes of a register: first clk_en one cycle after reset release,
    // smp_en after 7 and sym_en after 31.
    assign clk_en = phase_reg[0];
    assign smp_en = (phase_reg[2:0] == SMP_MASK);
    assign sym_en = (phase_reg == SYM_PHASE);

endmodule

// File: rtl/mer_measure_sequencer.sv
// MER measurement sequencer. Generates sample/symbol rate enables and runs the
// interval FSM: clear the accumulators on a symbol, discard SETTLE_SYMS
// symbols, accumulate 2**ACC_LEN_LOG2 symbols, capture, then offer the result
// over a valid/ready handshake.
// Ports:
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high
//   bus      : mer_measure_sequencer_if.master (requests, enables, strobes,
//              result handshake, busy/sym_count/interval_count)
module mer_measure_sequencer
    import mer_seq_pkg::*;
#(
    parameter int ACC_LEN_LOG2 = 18,
    parameter int SETTLE_SYMS  = 16,
    parameter int CNT_W        = 16
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    mer_measure_sequencer_if.master bus
);

    localparam int SETTLE_W = (SETTLE_SYMS > 1) ? $clog2(SETTLE_SYMS) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_SYMS - 1);

    logic clk_en;
    logic smp_en;
    logic sym_en;

    mer_enable_gen u_enable_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clk_en   (clk_en),
        .smp_en   (smp_en),
        .sym_en   (sym_en)
    );

    seq_state_t              state_reg;
    logic [SETTLE_W-1:0]     settle_cnt_reg;
    logic [ACC_LEN_LOG2-1:0] sym_count_reg;
    logic [CNT_W-1:0]        interval_count_reg;

    logic sym_last;
    logic handshake;

    assign sym_last  = &sym_count_reg;
    // res_valid is exactly "state is REPORT", so the handshake needs no extra flop.
    assign handshake = (state_reg == REPORT) && bus.res_ready;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg          <= IDLE;
            settle_cnt_reg     <= '0;
            sym_count_reg      <= '0;
            interval_count_reg <= '0;
        end else if (bus.abort) begin
            // Abort wins over everything, including a simultaneous start;
            // the completed-interval tally survives.
            state_reg      <= IDLE;
            settle_cnt_reg <= '0;
            sym_count_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start || bus.continuous) begin
                        state_reg <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (sym_en) begin
                        state_reg      <= SETTLE;
                        settle_cnt_reg <= '0;
                    end
                end
                SETTLE: begin
                    if (sym_en) begin
                        if (settle_cnt_reg == SETTLE_LAST) begin
                            state_reg     <= ACCUM;
                            sym_count_reg <= '0;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg + 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (sym_en) begin
                        if (sym_last) begin
                            state_reg     <= REPORT;
                            sym_count_reg <= '0;
                        end else begin
                            sym_count_reg <= sym_count_reg + 1'b1;
                        end
                    end
                end
                REPORT: begin
                    // Held here under backpressure; nothing else is strobed.
                    if (handshake) begin
                        interval_count_reg <= interval_count_reg + 1'b1;
                        state_reg          <= bus.continuous ? CLEAR : IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Strobes must coincide with sym_en, so they are decoded from the
    // registered state and the registered phase rather than delayed a cycle.
    // An abort in the same cycle suppresses them.
    assign bus.clear_accum = (state_reg == CLEAR) && sym_en && !bus.abort;
    assign bus.capture     = (state_reg == ACCUM) && sym_en && sym_last && !bus.abort;

    assign bus.res_valid      = (state_reg == REPORT);
    assign bus.busy           = (state_reg != IDLE);
    assign bus.sym_count      = sym_count_reg;
    assign bus.interval_count = interval_count_reg;
    assign bus.clk_en         = clk_en;
    assign bus.smp_en         = smp_en;
    assign bus.sym_en         = sym_en;

endmodule

// File: tb/tb_mer_measure_sequencer.sv
// Bench for mer_measure_sequencer with ACC_LEN_LOG2=4, SETTLE_SYMS=2.
// Cycle n is the interval after the n-th rising edge following reset release;
// inputs for cycle n are driven on the falling edge and outputs sampled 1 time
// unit later.
module tb_mer_measure_sequencer;

    localparam int ACC_LEN_LOG2 = 4;
    localparam int SETTLE_SYMS  = 2;
    localparam int CNT_W        = 16;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    always #5 CLOCK_50 = ~CLOCK_50;

    mer_measure_sequencer_if #(.ACC_LEN_LOG2(ACC_LEN_LOG2), .CNT_W(CNT_W)) bus ();

    mer_measure_sequencer #(
        .ACC_LEN_LOG2 (ACC_LEN_LOG2),
        .SETTLE_SYMS  (SETTLE_SYMS),
        .CNT_W        (CNT_W)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit start0;      // start pulse in cycle 0
        int start2_cyc;  // second start pulse (-1 = none)
        bit cont;        // continuous level from cycle 0
        int cont_drop;   // cycle continuous falls (-1 = never)
        int ready_cyc;   // res_ready high from this cycle on
        int abort_cyc;   // abort pulse cycle (-1 = none)
        int run_len;
        int exp_clear1;
        int exp_clear2;
        int exp_nclear;
        int exp_cap1;
        int exp_cap2;
        int exp_ncap;
        int exp_vfirst;
        int exp_vlast;
        int exp_icount;
        int exp_busy_end;
        int exp_idle;    // first non-busy cycle after starting (0 = never)
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        cyc++;
    endtask

    task automatic clear_inputs();
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.abort      = 1'b0;
        bus.res_ready  = 1'b0;
    endtask

    // Holds reset for a few edges and releases it at a falling edge: the
    // following interval is cycle 0.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic drive(input vec_t v, input int c);
        bus.start      = (v.start0 && c == 0) || (c == v.start2_cyc);
        bus.continuous = v.cont && (v.cont_drop < 0 || c < v.cont_drop);
        bus.res_ready  = (c >= v.ready_cyc);
        bus.abort      = (c == v.abort_cyc);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nclear = 0, ncap = 0;
        int c1 = 0, c2 = 0, p1 = 0, p2 = 0;
        int vfirst = 0, vlast = 0, idle = 0;
        bit seen_busy = 1'b0;
        do_reset();
        drive(v, 0);
        while (cyc < v.run_len) begin
            step();
            drive(v, cyc);
            #1;
            if (bus.clear_accum) begin
                nclear++;
                if (nclear == 1) c1 = cyc;
                else if (nclear == 2) c2 = cyc;
            end
            if (bus.capture) begin
                ncap++;
                if (ncap == 1) p1 = cyc;
                else if (ncap == 2) p2 = cyc;
            end
            if (bus.res_valid) begin
                if (vfirst == 0) vfirst = cyc;
                vlast = cyc;
            end
            if (bus.busy) seen_busy = 1'b1;
            else if (seen_busy && idle == 0) idle = cyc;
        end
        chk($sformatf("v%0d clear1_cycle", idx), c1, v.exp_clear1);
        chk($sformatf("v%0d clear2_cycle", idx), c2, v.exp_clear2);
        chk($sformatf("v%0d clear_count", idx), nclear, v.exp_nclear);
        chk($sformatf("v%0d capture1_cycle", idx), p1, v.exp_cap1);
        chk($sformatf("v%0d capture2_cycle", idx), p2, v.exp_cap2);
        chk($sformatf("v%0d capture_count", idx), ncap, v.exp_ncap);
        chk($sformatf("v%0d valid_first", idx), vfirst, v.exp_vfirst);
        chk($sformatf("v%0d valid_last", idx), vlast, v.exp_vlast);
        chk($sformatf("v%0d interval_count", idx), bus.interval_count, v.exp_icount);
        chk($sformatf("v%0d busy_end", idx), bus.busy, v.exp_busy_end);
        chk($sformatf("v%0d idle_cycle", idx), idle, v.exp_idle);
        $display("vec %0d: clears=%0d@%0d,%0d captures=%0d@%0d,%0d valid=%0d..%0d icount=%0d idle@%0d",
                 idx, nclear, c1, c2, ncap, p1, p2, vfirst, vlast, bus.interval_count, idle);
    endtask

    initial begin
        int k;
        // start0 s2  cont drop ready abort len | clr1 clr2 nclr cap1 cap2 ncap vf vl ic busy idle
        vecs[0] = '{1, -1, 0, -1, 0,      -1,  700, 31, 0,   1, 607, 0,    1, 608, 608,  1, 0, 609}; // one-shot, ready
        vecs[1] = '{1, -1, 0, -1, 800,    -1,  900, 31, 0,   1, 607, 0,    1, 608, 800,  1, 0, 801}; // backpressure
        vecs[2] = '{0, -1, 1, -1, 0,      -1, 1230, 31, 639, 2, 607, 1215, 2, 608, 1216, 2, 1, 0};   // continuous
        vecs[3] = '{1, 320, 0, -1, 0,     320, 700, 31, 0,   1, 0,   0,    0, 0,   0,    0, 0, 321}; // abort+start
        vecs[4] = '{0, -1, 1, 300, 0,     -1,  700, 31, 0,   1, 607, 0,    1, 608, 608,  1, 0, 609}; // continuous drops
        vecs[5] = '{1, -1, 0, -1, 100000, 650, 700, 31, 0,   1, 607, 0,    1, 608, 650,  0, 0, 651}; // abort in REPORT

        // Reset state while reset is held.
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        #1;
        chk("rst clk_en", bus.clk_en, 0);
        chk("rst smp_en", bus.smp_en, 0);
        chk("rst sym_en", bus.sym_en, 0);
        chk("rst clear_accum", bus.clear_accum, 0);
        chk("rst capture", bus.capture, 0);
        chk("rst res_valid", bus.res_valid, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst sym_count", bus.sym_count, 0);
        chk("rst interval_count", bus.interval_count, 0);

        // Idle enable cadence after release.
        do_reset();
        while (cyc < 100) begin
            step();
            #1;
            chk("idle clk_en", bus.clk_en, (cyc % 2 == 1));
            chk("idle smp_en", bus.smp_en, (cyc % 8 == 7));
            chk("idle sym_en", bus.sym_en, (cyc % 32 == 31));
            chk("idle strobes", {bus.clear_accum, bus.capture, bus.res_valid, bus.busy}, 0);
        end
        $display("idle cadence: checked cycles 1..100");

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of REPORT with the consumer stalled.
        do_reset();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (cyc < 300) step();
        #1;
        chk("mid sym_count@300", bus.sym_count, 6);
        while (cyc < 610) step();
        #1;
        chk("mid res_valid@610", bus.res_valid, 1);
        reset = 1'b1;
        step();
        #1;
        chk("rerst res_valid", bus.res_valid, 0);
        chk("rerst busy", bus.busy, 0);
        chk("rerst sym_count", bus.sym_count, 0);
        chk("rerst sym_en", bus.sym_en, 0);
        chk("rerst clk_en", bus.clk_en, 0);
        reset = 1'b0;
        k = 0;
        while (k < 40) begin
            step();
            k++;
            #1;
            if (bus.sym_en) break;
        end
        chk("rerst cycles_to_sym_en", k, 31);
        chk("rerst busy_after", bus.busy, 0);
        $display("mid-report reset: first sym_en %0d cycles after release", k);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
